// File: rtl/trace_pkg.sv
// Shared types for the trace checker: golden entry, checker state,
// default end-of-test PC and byte-enable to bit-mask expansion.
package trace_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } golden_t;

    typedef enum logic [1:0] {
        RUN,
        PASS,
        FAIL
    } state_t;

    localparam logic [31:0] END_PC_DEFAULT = 32'h1c00_0100;

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/trace_checker_if.sv
// Golden valid/ready stream plus the CPU write-back debug bus.
// master drives golden entries and the trace; slave is the checker.
interface trace_checker_if;

    logic        golden_valid;
    logic        golden_ready;
    logic [31:0] golden_pc;
    logic [4:0]  golden_wnum;
    logic [31:0] golden_wdata;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    modport master (
        output golden_valid,
        output golden_pc,
        output golden_wnum,
        output golden_wdata,
        output debug_wb_pc,
        output debug_wb_rf_we,
        output debug_wb_rf_wnum,
        output debug_wb_rf_wdata,
        input  golden_ready
    );

    modport slave (
        input  golden_valid,
        input  golden_pc,
        input  golden_wnum,
        input  golden_wdata,
        input  debug_wb_pc,
        input  debug_wb_rf_we,
        input  debug_wb_rf_wnum,
        input  debug_wb_rf_wdata,
        output golden_ready
    );

endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO with first-word-fall-through head; pointers carry
// one extra wrap bit so full/empty need no separate counter.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 69
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance, guarded so misuse cannot corrupt occupancy
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    // Pointer registers; reset flushes the contents
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; data needs no reset since empty masks it
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/trace_checker.sv
// Compares each CPU register-file commit with the next golden entry,
// counts passes/errors, captures the first error, ends at END_PC.
module trace_checker
    import trace_pkg::*;
#(
    parameter int          FIFO_DEPTH    = 8,
    parameter logic [31:0] END_PC        = END_PC_DEFAULT,
    parameter bit          STOP_ON_ERROR = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    trace_checker_if.slave bus,
    output logic [31:0]    pass_cnt,
    output logic [15:0]    err_cnt,
    output logic           done,
    output logic           fail,
    output logic           underflow,
    output logic [31:0]    err_pc,
    output logic [31:0]    err_exp_wdata,
    output logic [31:0]    err_got_wdata,
    output logic [4:0]     err_wnum
);

    state_t      state_q, state_d;
    logic [31:0] pass_cnt_q, pass_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        underflow_q, underflow_d;
    logic [31:0] err_pc_q, err_pc_d;
    logic [31:0] err_exp_q, err_exp_d;
    logic [31:0] err_got_q, err_got_d;
    logic [4:0]  err_wnum_q, err_wnum_d;

    golden_t     push_ent, head;
    logic        full, empty, push, pop;
    logic        commit, mism, err_ev, pass_ev;
    logic [31:0] mask;

    assign push_ent = '{pc:    bus.golden_pc,
                        wnum:  bus.golden_wnum,
                        wdata: bus.golden_wdata};

    // Ready is state/full only: no path from the debug bus
    assign bus.golden_ready = !full && (state_q == RUN);
    assign push = bus.golden_valid && bus.golden_ready;

    trace_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(golden_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (push_ent),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // Commit detection and masked comparison against the FIFO head
    always_comb begin
        commit  = (state_q == RUN) && (|bus.debug_wb_rf_we) &&
                  (bus.debug_wb_rf_wnum != 5'd0);
        mask    = be_to_mask(bus.debug_wb_rf_we);
        mism    = (head.pc != bus.debug_wb_pc) ||
                  (head.wnum != bus.debug_wb_rf_wnum) ||
                  (((bus.debug_wb_rf_wdata ^ head.wdata) & mask) != 32'd0);
        pop     = commit && !empty;
        pass_ev = pop && !mism;
        err_ev  = commit && (empty || mism);
    end

    // Counters, first-error capture and RUN/PASS/FAIL next state
    always_comb begin
        state_d     = state_q;
        pass_cnt_d  = pass_cnt_q;
        err_cnt_d   = err_cnt_q;
        underflow_d = underflow_q;
        err_pc_d    = err_pc_q;
        err_exp_d   = err_exp_q;
        err_got_d   = err_got_q;
        err_wnum_d  = err_wnum_q;
        if (pass_ev && (pass_cnt_q != '1)) begin
            pass_cnt_d = pass_cnt_q + 32'd1;
        end
        if (commit && empty) begin
            underflow_d = 1'b1;
        end
        if (err_ev) begin
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
            if (err_cnt_q == 16'd0) begin
                err_pc_d   = bus.debug_wb_pc;
                err_exp_d  = empty ? 32'd0 : head.wdata;
                err_got_d  = bus.debug_wb_rf_wdata;
                err_wnum_d = bus.debug_wb_rf_wnum;
            end
        end
        unique case (state_q)
            RUN: begin
                if (err_ev && STOP_ON_ERROR) begin
                    state_d = FAIL;
                end else if (bus.debug_wb_pc == END_PC) begin
                    state_d = (err_cnt_q == 16'd0 && !err_ev) ? PASS : FAIL;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // State and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            pass_cnt_q  <= '0;
            err_cnt_q   <= '0;
            underflow_q <= 1'b0;
            err_pc_q    <= '0;
            err_exp_q   <= '0;
            err_got_q   <= '0;
            err_wnum_q  <= '0;
        end else begin
            state_q     <= state_d;
            pass_cnt_q  <= pass_cnt_d;
            err_cnt_q   <= err_cnt_d;
            underflow_q <= underflow_d;
            err_pc_q    <= err_pc_d;
            err_exp_q   <= err_exp_d;
            err_got_q   <= err_got_d;
            err_wnum_q  <= err_wnum_d;
        end
    end

    assign pass_cnt      = pass_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign done          = (state_q != RUN);
    assign fail          = (state_q == FAIL);
    assign underflow     = underflow_q;
    assign err_pc        = err_pc_q;
    assign err_exp_wdata = err_exp_q;
    assign err_got_wdata = err_got_q;
    assign err_wnum      = err_wnum_q;

endmodule
